pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller that drives the write-enable and synchronous-clear inputs of the PC register and the four inter-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, taken branches resolved in EX, and multi-cycle memory waits with timeout.
- Converts them into per-stage enable/flush decisions for the next clock edge.
- A flush is wired to a buffer's clear input; a cleared buffer (all zeros) is a NOP bubble.

Parameters:
RW, 3, register-address width of rd/rs fields
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before abort; 0 = no timeout
PCW, 16, width of optional performance counters

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous active-high reset
idex_mem_read  in  1  instruction in EX is a load
idex_rd  in  RW  destination register of instruction in EX
idex_rd_valid  in  1  instruction in EX writes idex_rd
ifid_rs1  in  RW  source 1 of instruction in ID
ifid_rs2  in  RW  source 2 of instruction in ID
ifid_use_rs1  in  1  ID instruction reads rs1
ifid_use_rs2  in  1  ID instruction reads rs2
branch_taken  in  1  EX resolved a taken branch/jump this cycle
exmem_mem_access  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC write enable
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  buffer write enables
ifid_flush, idex_flush, memwb_flush  out  1 each  buffer synchronous clear
mem_err  out  1  one-cycle pulse: memory access aborted on timeout
state_o  out  2  current FSM state (debug)

Behaviour:
- Enables/flushes: combinational (Mealy) from state and inputs. mem_err, counters and state: registered.
- Definitions:
  - load_use = idex_mem_read & idex_rd_valid & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
  - mem_busy = exmem_mem_access & ~mem_ready.
- Default "normal" outputs: all en = 1, all flush = 0.
- States: RUN=0, LU_STALL=1, MEM_WAIT=2.
- RUN, priority highest first:
  1. mem_busy: freeze. All five en = 0, flushes = 0, wait counter <= 1, next MEM_WAIT.
  2. branch_taken: normal, plus ifid_flush = 1 and idex_flush = 1. Stay RUN. Branch overrides a simultaneous load_use.
  3. load_use: pc_en = 0, ifid_en = 0, idex_flush = 1 (bubble); exmem_en = memwb_en = 1; next LU_STALL.
  4. Otherwise normal.
- LU_STALL: load_use is masked.
  - mem_busy: freeze, next MEM_WAIT.
  - branch_taken: flush as in RUN.
  - Else normal.
  - Next RUN unless entering MEM_WAIT. Back-to-back stalls therefore never exceed 1 cycle per load.
- MEM_WAIT:
  - mem_ready=1: release with normal outputs (branch_taken and load_use evaluated as in RUN, same priority), next per those RUN rules (RUN or LU_STALL), counter <= 0.
  - mem_ready=0 and MEM_TIMEOUT!=0 and counter==MEM_TIMEOUT: abort. Normal outputs plus memwb_flush = 1 (failed access not committed), mem_err = 1 next cycle for exactly 1 cycle, next RUN, counter <= 0.
  - Else: freeze, counter++. Counter width clog2(MEM_TIMEOUT+1), never wraps.
- Reset: while rst=1, all en = 0, all flush = 0, mem_err = 0.
  - Next state RUN, counter 0, perf counters 0.
  - Reset asserted mid-MEM_WAIT or mid-stall aborts immediately, with no mem_err.
- mem_ready asserted with exmem_mem_access=0 is ignored.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: add outputs stall_cycles (PCW) and flush_events (PCW), registered and saturating at all-ones.
  - stall_cycles increments every cycle pc_en=0 outside reset.
  - flush_events increments every cycle any flush output = 1.
  - Both clear on rst.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd_valid=1, idex_rd=3, ifid_use_rs2=1, ifid_rs2=3 -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle state_o=1, outputs normal; then state_o=0.
- Branch + load_use same cycle: branch_taken=1 with load_use true -> pc_en=1, ifid_flush=1, idex_flush=1, state stays 0.
- Memory wait: exmem_mem_access=1, mem_ready=0 for 4 cycles then 1 -> all en=0 for 4 cycles, state_o=2; release cycle all en=1, next state 0, mem_err never set.
- Timeout, MEM_TIMEOUT=4: mem_ready held 0 -> freeze cycles 1-4; abort cycle has memwb_flush=1 and all en=1; mem_err=1 for exactly the following cycle; state 0.
- Reset mid-MEM_WAIT: rst=1 at wait cycle 2 -> en all 0 during rst, state_o=0 after, mem_err stays 0.
- HAZARD_PERF_CNT_EN, PCW=4: 20 stall cycles -> stall_cycles saturates at 15; rst -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the PC and the four inter-stage pipeline buffers.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int RW          = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int PCW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          idex_mem_read,
    input  logic [RW-1:0] idex_rd,
    input  logic          idex_rd_valid,
    input  logic [RW-1:0] ifid_rs1,
    input  logic [RW-1:0] ifid_rs2,
    input  logic          ifid_use_rs1,
    input  logic          ifid_use_rs2,
    input  logic          branch_taken,
    input  logic          exmem_mem_access,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          memwb_en,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          memwb_flush,
    output logic          mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PCW-1:0] stall_cycles,
    output logic [PCW-1:0] flush_events,
`endif
    output logic [1:0]    state_o
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [1:0]    ST_RUN   = 2'd0;
    localparam logic [1:0]    ST_LU    = 2'd1;
    localparam logic [1:0]    ST_MW    = 2'd2;
    localparam logic [CW-1:0] CNT_LIM  = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          mem_err_r;
    logic          abort_s;
    logic          load_use_s;
    logic          mem_busy_s;
    logic          timeout_s;

    assign load_use_s = idex_mem_read & idex_rd_valid &
                        ((ifid_use_rs1 & (ifid_rs1 == idex_rd)) |
                         (ifid_use_rs2 & (ifid_rs2 == idex_rd)));
    assign mem_busy_s = exmem_mem_access & ~mem_ready;
    assign timeout_s  = (MEM_TIMEOUT != 0) && (cnt_r == CNT_LIM);
    assign state_o    = state_r;
    assign mem_err    = mem_err_r;

    // Mealy enable/flush decode and next-state/counter selection
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        abort_s     = 1'b0;
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = CNT_ZERO;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else begin
            case (state_r)
                ST_RUN, ST_LU: begin
                    if (mem_busy_s) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        cnt_nxt_s   = CNT_ONE;
                        state_nxt_s = ST_MW;
                    end else if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (load_use_s && (state_r == ST_RUN)) begin
                        // A load-use seen in LU_STALL is the same hazard: one bubble per load
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_flush  = 1'b1;
                        state_nxt_s = ST_LU;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_MW: begin
                    if (!mem_busy_s) begin
                        if (branch_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (load_use_s) begin
                            pc_en       = 1'b0;
                            ifid_en     = 1'b0;
                            idex_flush  = 1'b1;
                            state_nxt_s = ST_LU;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else if (timeout_s) begin
                        memwb_flush = 1'b1;
                        abort_s     = 1'b1;
                    end else begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                        state_nxt_s = ST_MW;
                        if (cnt_r != CNT_MAX) begin
                            cnt_nxt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_nxt_s = cnt_r;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State, wait counter and one-cycle abort pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            cnt_r     <= CNT_ZERO;
            mem_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mem_err_r <= abort_s;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PCW-1:0] PC_MAX = {PCW{1'b1}};
    localparam logic [PCW-1:0] PC_ONE = PCW'(1'b1);

    // Saturating stall-cycle and flush-event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= {PCW{1'b0}};
            flush_events <= {PCW{1'b0}};
        end else begin
            if (!pc_en && (stall_cycles != PC_MAX)) begin
                stall_cycles <= stall_cycles + PC_ONE;
            end else begin
                stall_cycles <= stall_cycles;
            end
            if ((ifid_flush | idex_flush | memwb_flush) && (flush_events != PC_MAX)) begin
                flush_events <= flush_events + PC_ONE;
            end else begin
                flush_events <= flush_events;
            end
        end
    end
`endif

endmodule
